bus_timer: RTL
==============

// Module: bus_timer
// PURPOSE
// - Bus follower peripheral: 32-bit timer/compare with prescaler, match flag and interrupt.
// - Sits on one followers[] slot of system_bus; responds to read_req/write_req on its decoded region.
// - Responder end of the bus protocol: single-cycle write accept, fixed 1-cycle read latency.
// PARAMETERS
// - PRESCALE_W  16  width of prescaler reload register/counter (1..32)
// - RESET_CMP   32'hFFFF_FFFF  reset value of COMPARE
// PORTS
// - clk              input   1   system clock, all logic rising-edge
// - reset            input   1   synchronous, active-high reset
// - bus.addr         input   32  byte address; word offset = addr[4:2], other bits ignored
// - bus.write_data   input   32  write data
// - bus.byte_enable  input   4   per-byte write enable, bit n -> data[8n+7:8n]
// - bus.read_req     input   1   read strobe, one cycle per access
// - bus.write_req    input   1   write strobe, one cycle per access
// - bus.read_data    output  32  read data; 0 whenever read_data_valid=0
// - bus.read_data_valid output 1 pulses exactly 1 cycle after accepted read_req
// - capture_in       input   1   async-free capture strobe (used only with macro)
// - irq              output  1   level interrupt = STATUS.match & CTRL.irq_en
// BEHAVIOUR
// - Reset: CTRL=0, COUNT=0, COMPARE=RESET_CMP, PRESCALE=0, STATUS=0, prescale ctr=0,
//   read_data=0, read_data_valid=0, irq=0. Reset mid-read: no valid pulse follows.
// - Map (word offset): 0 CTRL{irq_en[2],autoreload[1],enable[0]}, 1 COUNT, 2 COMPARE,
//   3 PRESCALE[PRESCALE_W-1:0], 4 STATUS{capture[1],match[0]} W1C, 5 CAPTURE (macro), 6-7 read 0.
// - Writes: applied at edge where write_req=1, byte-masked; unimplemented bits ignore, read 0.
// - Reads: sample register at read_req edge; data+valid next cycle; back-to-back reads OK (1/cycle).
// - Read+write same cycle, same reg: read returns pre-write value.
// - Tick: enable=1 and prescale ctr==PRESCALE -> tick, ctr<=0; else ctr++ while enabled.
//   PRESCALE=0 -> tick every cycle. enable=0 freezes COUNT and clears prescale ctr.
// - On tick: if COUNT==COMPARE -> STATUS.match<=1; COUNT<=autoreload?0:COUNT+1.
//   Else COUNT<=COUNT+1, wraps FFFF_FFFF->0 with no flag.
// - Priority on COUNT: bus write > tick. Write to COUNT on a tick cycle suppresses match check.
// - STATUS: hardware set beats W1C in same cycle (flag stays 1).
// - irq combinational from registered STATUS/CTRL, no extra latency.
// CONFIGURATION
// - BUS_TIMER_CAPTURE_EN defined: capture_in synchronised 2 FFs, rising edge latches COUNT
//   into CAPTURE and sets STATUS.capture; irq = (match|capture) & irq_en.
// - Not defined: capture_in ignored, CAPTURE reads 0, STATUS.capture reads 0, irq from match only.
// TESTING
// - Reset, read offsets 0-7 -> valid 1 cycle after each req; CMP=FFFF_FFFF, rest 0; no valid w/o req.
// - Write CTRL=1, PRESCALE=0, COMPARE=5 -> STATUS.match=1 on 6th tick; COUNT continues 6,7.
// - CTRL=7, PRESCALE=3, COMPARE=2 -> COUNT incs every 4 cycles, 0,1,2,0; irq high after first match.
// - Write STATUS=1 on same cycle as new match -> match stays 1; later W1C -> irq drops next cycle.
// - COUNT=FFFF_FFFE, COMPARE=0, enable -> wraps to 0 with no flag, match set on the following tick.
// - Byte write be=4'b0010 data=AABBCCDD to COMPARE -> reads FFFF_CCFF; with macro, capture_in
//   pulse at COUNT=10 -> CAPTURE=10 (+sync delay 2-3), STATUS.capture=1.

Source files
------------

// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
// Bus follower peripheral with a 32-bit timer/compare unit. It has a
// programmable prescaler, a sticky match flag and a level interrupt.
// Writes are accepted in a single cycle. Reads have a fixed 1-cycle latency.
//
// Register map (word offset = i_addr[4:2]):
//   0 CTRL     {irq_en[2], autoreload[1], enable[0]}
//   1 COUNT    32-bit counter
//   2 COMPARE  32-bit compare value
//   3 PRESCALE [PRESCALE_W-1:0] tick divider reload (0 = tick every cycle)
//   4 STATUS   {capture[1], match[0]}, write-1-to-clear
//   5 CAPTURE  COUNT latched on a capture_in rising edge
//   6-7        read as 0
//
// Optional feature macro: BUS_TIMER_CAPTURE_EN
//   Defined     : i_capture_in is synchronised through 2 FFs. A rising edge
//                 latches COUNT into CAPTURE and sets STATUS.capture.
//   Not defined : i_capture_in is ignored. CAPTURE and STATUS.capture read 0.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_reset            synchronous active-high reset
//   i_addr[31:0]       byte address, only [4:2] decoded
//   i_write_data[31:0] write data
//   i_byte_enable[3:0] per-byte write enable
//   i_read_req         read strobe, one cycle per access
//   i_write_req        write strobe, one cycle per access
//   o_read_data[31:0]  read data, 0 unless o_read_data_valid
//   o_read_data_valid  pulses 1 cycle after an accepted read_req
//   i_capture_in       capture strobe (used only with the macro)
//   o_irq              (STATUS.match | STATUS.capture) & CTRL.irq_en
// -----------------------------------------------------------------------------
module bus_timer #(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] RESET_CMP  = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic [3:0]  i_byte_enable,
  input  logic        i_read_req,
  input  logic        i_write_req,
  output logic [31:0] o_read_data,
  output logic        o_read_data_valid,
  input  logic        i_capture_in,
  output logic        o_irq
);

  typedef enum logic [2:0] {
    OFF_CTRL     = 3'd0,
    OFF_COUNT    = 3'd1,
    OFF_COMPARE  = 3'd2,
    OFF_PRESCALE = 3'd3,
    OFF_STATUS   = 3'd4,
    OFF_CAPTURE  = 3'd5,
    OFF_RSV6     = 3'd6,
    OFF_RSV7     = 3'd7
  } reg_off_e;

  // Byte-masked merge of write data into the current register value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] data,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  logic [2:0]            r_ctrl;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pre_ctr;
  logic                  r_match;
  logic [31:0]           r_read_data;
  logic                  r_read_valid;

  reg_off_e    w_off;
  logic        w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_prescale, w_wr_status;
  logic        w_tick, w_cnt_hit, w_match_set, w_match_w1c;
  logic        w_cap_flag;
  logic [31:0] w_capture;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_off         = reg_off_e'(i_addr[4:2]);
  assign w_wr_ctrl     = i_write_req && (w_off == OFF_CTRL);
  assign w_wr_count    = i_write_req && (w_off == OFF_COUNT);
  assign w_wr_compare  = i_write_req && (w_off == OFF_COMPARE);
  assign w_wr_prescale = i_write_req && (w_off == OFF_PRESCALE);
  assign w_wr_status   = i_write_req && (w_off == OFF_STATUS);

  assign w_tick      = r_ctrl[0] && (r_pre_ctr == r_prescale);
  assign w_cnt_hit   = (r_count == r_compare);
  // A bus write to COUNT takes priority over the tick, so it also cancels the match check.
  assign w_match_set = w_tick && w_cnt_hit && !w_wr_count;
  assign w_match_w1c = w_wr_status && i_byte_enable[0] && i_write_data[0];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others. That is what makes a read
  // return the pre-write value when read and write hit the same register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctrl       <= '0;
      r_count      <= '0;
      r_compare    <= RESET_CMP;
      r_prescale   <= '0;
      r_pre_ctr    <= '0;
      r_match      <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      if (w_wr_ctrl)     r_ctrl     <= 3'(f_merge(32'(r_ctrl), i_write_data, i_byte_enable));
      if (w_wr_compare)  r_compare  <= f_merge(r_compare, i_write_data, i_byte_enable);
      if (w_wr_prescale) r_prescale <= PRESCALE_W'(f_merge(32'(r_prescale), i_write_data,
                                                           i_byte_enable));

      if (w_wr_count)
        r_count <= f_merge(r_count, i_write_data, i_byte_enable);
      else if (w_tick)
        r_count <= (w_cnt_hit && r_ctrl[1]) ? '0 : r_count + 32'd1;

      // If PRESCALE is lowered below the running count, the counter wraps
      // round once before the next tick. This is harmless.
      if (!r_ctrl[0] || w_tick) r_pre_ctr <= '0;
      else                      r_pre_ctr <= r_pre_ctr + PRESCALE_W'(1);

      // The hardware set is ORed in after the clear, so the set wins when both happen together.
      r_match <= w_match_set | (r_match & ~w_match_w1c);

      r_read_valid <= i_read_req;
      r_read_data  <= i_read_req ? w_rd_mux : '0;
    end
  end

`ifdef BUS_TIMER_CAPTURE_EN
  logic [1:0]  r_cap_sync;
  logic        r_cap_sync_d;
  logic        r_cap_flag;
  logic [31:0] r_capture;
  logic        w_cap_rise, w_cap_w1c;

  assign w_cap_rise = r_cap_sync[1] & ~r_cap_sync_d;
  assign w_cap_w1c  = w_wr_status && i_byte_enable[0] && i_write_data[1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cap_sync   <= '0;
      r_cap_sync_d <= 1'b0;
      r_cap_flag   <= 1'b0;
      r_capture    <= '0;
    end else begin
      r_cap_sync   <= {r_cap_sync[0], i_capture_in};
      r_cap_sync_d <= r_cap_sync[1];
      if (w_cap_rise) r_capture <= r_count;
      r_cap_flag   <= w_cap_rise | (r_cap_flag & ~w_cap_w1c);
    end
  end

  assign w_cap_flag = r_cap_flag;
  assign w_capture  = r_capture;
  assign w_unused   = &{1'b0, i_addr[31:5], i_addr[1:0]};
`else
  assign w_cap_flag = 1'b0;
  assign w_capture  = '0;
  assign w_unused   = &{1'b0, i_addr[31:5], i_addr[1:0], i_capture_in};
`endif

  // NOTE: the default is assigned first, so no path through the case leaves
  // w_rd_mux unassigned. This keeps the block free of inferred latches.
  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_CTRL:     w_rd_mux = 32'(r_ctrl);
      OFF_COUNT:    w_rd_mux = r_count;
      OFF_COMPARE:  w_rd_mux = r_compare;
      OFF_PRESCALE: w_rd_mux = 32'(r_prescale);
      OFF_STATUS:   w_rd_mux = {30'b0, w_cap_flag, r_match};
      OFF_CAPTURE:  w_rd_mux = w_capture;
      default:      w_rd_mux = '0;
    endcase
  end

  assign o_read_data       = r_read_data;
  assign o_read_data_valid = r_read_valid;
  assign o_irq             = (r_match | w_cap_flag) & r_ctrl[2];

endmodule
